temp_sample_fifo: RTL and testbench

Synchronous buffer and read sequencer that sits directly upstream of the temperature averager in the clk_2 domain. Raw 8-bit sensor samples are written in one at a time. When a full group of samples is buffered, the block clears the averager, streams the group into it, and then strobes `avg_valid` so downstream logic knows the averaged reading is current.

---
 rtl/temp_sample_fifo_pkg.sv | 23 ++
 rtl/temp_sample_fifo_if.sv | 40 ++++
 rtl/temp_sample_fifo_mem.sv | 93 +++++++++
 rtl/temp_sample_fifo.sv | 127 ++++++++++++
 tb/tb_temp_sample_fifo.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/temp_sample_fifo_pkg.sv
// ---------------------------------------------------------------------------
// temp_pkg
// Shared types and constants for the temperature sample buffer and its
// read sequencer.
//   temp_t       : one raw sensor sample
//   seq_state_e  : read-sequencer FSM states
//   TEMP_GROUP   : samples per averaging group (matches averager divide-by-4)
// ---------------------------------------------------------------------------
package temp_pkg;

    localparam int unsigned TEMP_WIDTH = 8;
    localparam int unsigned TEMP_GROUP = 4;

    typedef logic [TEMP_WIDTH-1:0] temp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/temp_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// temp_sample_fifo_if
// Bundles the sample-write side and the averager-facing side of
// temp_sample_fifo.
//   wr_en, wr_data, ovf_clr          : driven by the sample producer (master)
//   rd, data_out, clear, avg_valid   : driven by the buffer (slave)
//   full, empty, count, overflow     : buffer status (slave)
// ---------------------------------------------------------------------------
interface temp_sample_fifo_if
    import temp_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = TEMP_WIDTH
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             ovf_clr;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic             clear;
    logic             avg_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  rd, data_out, clear, avg_valid, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output rd, data_out, clear, avg_valid, full, empty, count, overflow
    );

endinterface

// File: rtl/temp_sample_fifo_mem.sv
// ---------------------------------------------------------------------------
// temp_fifo_mem
// Circular sample store with write/read pointers and a separately tracked
// occupancy count. Read data is first-word fall-through from mem[rd_ptr].
// Ports:
//   clk_2, reset_n : clock, asynchronous active-low reset
//   i_wr_en        : write request (ignored while full, even if reading)
//   i_wr_data      : sample to store
//   i_rd           : pop head entry
//   o_data         : head-of-buffer sample
//   o_full/o_empty : registered status
//   o_count        : registered occupancy
//   o_wr_drop      : write request rejected this cycle
// ---------------------------------------------------------------------------
module temp_fifo_mem
    import temp_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = TEMP_WIDTH
) (
    input  logic                       clk_2,
    input  logic                       reset_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_wr_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_ok;
    logic [CW-1:0]    w_count_nxt;

    assign w_wr_ok = i_wr_en & ~r_full;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_ok, i_rd})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk_2) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Status flags are registered from the next count so they always
    // describe the state after the most recent edge.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data    = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;
    assign o_wr_drop = i_wr_en & r_full;

endmodule

// File: rtl/temp_sample_fifo.sv
// ---------------------------------------------------------------------------
// temp_sample_fifo
// Buffers raw temperature samples and, once a full group is present, clears
// the downstream averager, streams the group into it and pulses avg_valid.
// Ports:
//   clk_2    : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : temp_sample_fifo_if.slave (write side, averager side, status)
// Build option:
//   TEMP_FIFO_OVERFLOW_EN : enables the sticky overflow flag; when undefined
//                           overflow reads 0 and ovf_clr is ignored.
// ---------------------------------------------------------------------------
module temp_sample_fifo
    import temp_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = TEMP_WIDTH,
    parameter int unsigned GROUP = TEMP_GROUP
) (
    input  logic                clk_2,
    input  logic                reset_n,
    temp_sample_fifo_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CW-1:0] GROUP_CNT = CW'(GROUP);
    localparam logic [BW-1:0] LAST_BEAT = BW'(GROUP - 1);

    seq_state_e      r_state;
    seq_state_e      w_state_nxt;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_nxt;

    logic            w_rd;
    logic            w_clear;
    logic            w_avg_valid;
    logic            w_wr_drop;
    logic [CW-1:0]   w_count;
    logic            r_overflow;

    temp_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .i_wr_en   (bus.wr_en),
        .i_wr_data (bus.wr_data),
        .i_rd      (w_rd),
        .o_data    (bus.data_out),
        .o_full    (bus.full),
        .o_empty   (bus.empty),
        .o_count   (w_count),
        .o_wr_drop (w_wr_drop)
    );

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // READ is only entered through CLR, which is only entered with a whole
    // group buffered, so rd can never pop an empty buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_rd        = 1'b0;
        w_clear     = 1'b0;
        w_avg_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count >= GROUP_CNT) begin
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                w_clear     = 1'b1;
                w_beat_nxt  = '0;
                w_state_nxt = READ;
            end
            READ: begin
                w_rd       = 1'b1;
                w_beat_nxt = r_beat + BW'(1);
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_avg_valid = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef TEMP_FIFO_OVERFLOW_EN
    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end
`else
    logic w_unused_ovf;
    assign w_unused_ovf = &{1'b0, w_wr_drop, bus.ovf_clr};
    assign r_overflow   = 1'b0;
`endif

    assign bus.rd        = w_rd;
    assign bus.clear     = w_clear;
    assign bus.avg_valid = w_avg_valid;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_temp_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_temp_sample_fifo
// Directed bench for temp_sample_fifo. Honours TEMP_FIFO_OVERFLOW_EN for the
// expected overflow value.
// ---------------------------------------------------------------------------
module tb_temp_sample_fifo;
    import temp_pkg::*;

`ifdef TEMP_FIFO_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk_2   = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clk_2 = ~clk_2;

    temp_sample_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

    temp_sample_fifo #(
        .DEPTH (16),
        .WIDTH (8),
        .GROUP (4)
    ) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic push(input temp_t d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd"},    32'(bus.rd),        32'd0);
        check({tag, "_clear"}, 32'(bus.clear),     32'd0);
        check({tag, "_avgv"},  32'(bus.avg_valid), 32'd0);
        check({tag, "_full"},  32'(bus.full),      32'd0);
        check({tag, "_empty"}, 32'(bus.empty),     32'd1);
        check({tag, "_count"}, 32'(bus.count),     32'd0);
        check({tag, "_ovf"},   32'(bus.overflow),  32'd0);
    endtask

    // Called right after the edge that accepted the 4th sample of a group
    // with the FSM idle: expects clear, 4 rd beats, avg_valid, idle.
    task automatic run_group(input string tag, input temp_t d0, input temp_t d1,
                             input temp_t d2, input temp_t d3);
        temp_t exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        tick();
        check({tag, "_clear"}, 32'(bus.clear), 32'd1);
        check({tag, "_clr_rd"}, 32'(bus.rd), 32'd0);
        for (int unsigned b = 0; b < 4; b++) begin
            tick();
            check({tag, "_rd"},   32'(bus.rd),       32'd1);
            check({tag, "_data"}, 32'(bus.data_out), 32'(exp_d[b]));
        end
        tick();
        check({tag, "_avgv"},  32'(bus.avg_valid), 32'd1);
        check({tag, "_endrd"}, 32'(bus.rd),        32'd0);
        check({tag, "_count"}, 32'(bus.count),     32'd0);
        check({tag, "_empty"}, 32'(bus.empty),     32'd1);
        tick();
        check({tag, "_avgv_off"}, 32'(bus.avg_valid), 32'd0);
        check({tag, "_clr_off"},  32'(bus.clear),     32'd0);
    endtask

    temp_t q[$];

    initial begin
        logic  seen;
        int    drops;
        temp_t d;
        logic  exp_rd;
        logic  exp_clr;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;

        // Reset
        tick();
        tick();
        check_reset_vals("rst");
        reset_n = 1'b1;

        // Single group of four
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        check("g1_count4", 32'(bus.count), 32'd4);
        check("g1_empty0", 32'(bus.empty), 32'd0);
        run_group("g1", 8'h10, 8'h20, 8'h30, 8'h40);

        // Three samples must not start a group
        push(8'h51); push(8'h52); push(8'h53);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | bus.rd | bus.clear;
        end
        check("g3_idle", 32'(seen), 32'd0);
        check("g3_count", 32'(bus.count), 32'd3);
        push(8'h54);
        run_group("g3", 8'h51, 8'h52, 8'h53, 8'h54);

        // Continuous writes for 40 cycles from empty/IDLE. Groups are read at
        // a 7-cycle period, so the buffer fills after edge 31 and writes at
        // edges 32, 33, 34 and 39 are dropped.
        drops = 0;
        for (int k = 0; k < 40; k++) begin
            d = 8'(k + 128);
            bus.wr_en   = 1'b1;
            bus.wr_data = d;
            tick();
            if (k == 32 || k == 33 || k == 34 || k == 39) drops++;
            else q.push_back(d);
            exp_rd  = (k >= 5) && (((k - 5) % 7) < 4);
            exp_clr = (k >= 4) && (((k - 4) % 7) == 0);
            check("cont_rd",    32'(bus.rd),    32'(exp_rd));
            check("cont_clear", 32'(bus.clear), 32'(exp_clr));
            if (bus.rd) begin
                check("cont_data", 32'(bus.data_out), 32'(q[0]));
                void'(q.pop_front());
            end
            if (k == 31) begin
                check("full_set",   32'(bus.full),  32'd1);
                check("full_count", 32'(bus.count), 32'd16);
            end
            if (k == 32) begin
                check("drop_count", 32'(bus.count),    32'd16);
                check("drop_ovf",   32'(bus.overflow), 32'(OVF_EXP));
            end
            if (k == 34) begin
                check("rdfull_count", 32'(bus.count), 32'd15);
                check("rdfull_full",  32'(bus.full),  32'd0);
            end
            if (k == 35) check("wr_rd_count", 32'(bus.count), 32'd15);
            if (k == 38) begin
                check("refill_count", 32'(bus.count), 32'd16);
                check("refill_full",  32'(bus.full),  32'd1);
            end
        end
        bus.wr_en = 1'b0;

        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.rd) begin
                check("drain_data", 32'(bus.data_out), 32'(q[0]));
                void'(q.pop_front());
            end
        end
        check("drain_left",  32'(q.size()),   32'd0);
        check("drain_count", 32'(bus.count),  32'd0);
        check("drain_empty", 32'(bus.empty),  32'd1);
        check("drops",       32'(drops),      32'd4);
        check("ovf_sticky",  32'(bus.overflow), 32'(OVF_EXP));
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Reset during READ beat 2
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        tick();
        check("mr_clear", 32'(bus.clear), 32'd1);
        tick(); tick(); tick();
        check("mr_beat2_rd",   32'(bus.rd),       32'd1);
        check("mr_beat2_data", 32'(bus.data_out), 32'hA3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mr_async");
        tick();
        reset_n = 1'b1;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        run_group("mr_post", 8'hB1, 8'hB2, 8'hB3, 8'hB4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
